// File: rtl/scc_dmem_dump.sv
// Post-halt data-memory dump engine: streams a header record then (byte address, word) records.
// Optional `DUMP_SKIP_ZERO_EN suppresses zero words except the final one.
module scc_dmem_dump #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DEPTH      = 1024,
    parameter logic [31:0] WATCH_ADDR = 32'h0000_0190
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              halt_f,
    input  logic [1:0]        err_bits,
    output logic              dm_rd_en,
    output logic [ADDR_W-1:0] dm_rd_addr,
    input  logic [31:0]       dm_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_addr,
    output logic [31:0]       out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              watch_hit,
    output logic [31:0]       watch_value
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StHdr  = 3'd1;
    localparam logic [2:0] StRead = 3'd2;
    localparam logic [2:0] StWait = 3'd3;
    localparam logic [2:0] StSend = 3'd4;
    localparam logic [2:0] StDone = 3'd5;

    localparam logic [ADDR_W-1:0] LastPtr = ADDR_W'(DEPTH - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              armed_q;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_addr_q, out_addr_d;
    logic [31:0]       out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              watch_hit_q, watch_hit_d;
    logic [31:0]       watch_value_q, watch_value_d;

    logic [31:0] byte_addr;
    logic        is_last;
    logic        hs;
    logic        skip;

    assign byte_addr = {{(30 - ADDR_W){1'b0}}, ptr_q, 2'b00};
    assign is_last   = (ptr_q == LastPtr);
    assign hs        = out_valid_q & out_ready;

`ifdef DUMP_SKIP_ZERO_EN
    assign skip = (dm_rd_data == 32'd0) && !is_last;
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        out_valid_d   = out_valid_q;
        out_addr_d    = out_addr_q;
        out_data_d    = out_data_q;
        out_last_d    = out_last_q;
        busy_d        = busy_q;
        done_d        = done_q;
        watch_hit_d   = watch_hit_q;
        watch_value_d = watch_value_q;
        case (state_q)
            StIdle: begin
                // armed_q blocks a halt_f that coincides with reset release
                if (halt_f && armed_q) begin
                    state_d     = StHdr;
                    busy_d      = 1'b1;
                    out_valid_d = 1'b1;
                    out_addr_d  = 32'hFFFF_FFFF;
                    out_data_d  = {30'b0, err_bits};
                    out_last_d  = 1'b0;
                end
            end
            StHdr: begin
                if (hs) begin
                    out_valid_d = 1'b0;
                    state_d     = StRead;
                end
            end
            StRead: state_d = StWait;
            StWait: begin
                if (byte_addr == WATCH_ADDR) begin
                    watch_hit_d   = 1'b1;
                    watch_value_d = dm_rd_data;
                end
                if (skip) begin
                    ptr_d   = ptr_q + ADDR_W'(1);
                    state_d = StRead;
                end else begin
                    out_valid_d = 1'b1;
                    out_addr_d  = byte_addr;
                    out_data_d  = dm_rd_data;
                    out_last_d  = is_last;
                    state_d     = StSend;
                end
            end
            StSend: begin
                if (hs) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        state_d = StDone;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d   = ptr_q + ADDR_W'(1);
                        state_d = StRead;
                    end
                end
            end
            StDone: state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            ptr_q         <= '0;
            armed_q       <= 1'b0;
            out_valid_q   <= 1'b0;
            out_addr_q    <= '0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            watch_hit_q   <= 1'b0;
            watch_value_q <= '0;
        end else if (clk_en) begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            armed_q       <= 1'b1;
            out_valid_q   <= out_valid_d;
            out_addr_q    <= out_addr_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            watch_hit_q   <= watch_hit_d;
            watch_value_q <= watch_value_d;
        end
    end

    assign dm_rd_en    = clk_en & (state_q == StRead);
    assign dm_rd_addr  = ptr_q;
    assign out_valid   = out_valid_q;
    assign out_addr    = out_addr_q;
    assign out_data    = out_data_q;
    assign out_last    = out_last_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign watch_hit   = watch_hit_q;
    assign watch_value = watch_value_q;

endmodule

// File: tb/tb_scc_dmem_dump.sv
// Scoreboard bench for scc_dmem_dump: expected records queued at halt, popped by a monitor.
module tb_scc_dmem_dump;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        halt_f;
    logic [1:0]  err_bits;
    logic        dm_rd_en;
    logic [9:0]  dm_rd_addr;
    logic [31:0] dm_rd_data = '0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        watch_hit;
    logic [31:0] watch_value;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic        l;
    } rec_t;

    rec_t        sb[$];
    logic [31:0] mem [0:1023];
    int          n_chk = 0;
    int          n_fail = 0;
    int          rx_count = 0;
    int          exp_count = 0;

    always #5 clk = ~clk;

    scc_dmem_dump dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .halt_f     (halt_f),
        .err_bits   (err_bits),
        .dm_rd_en   (dm_rd_en),
        .dm_rd_addr (dm_rd_addr),
        .dm_rd_data (dm_rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .watch_hit  (watch_hit),
        .watch_value(watch_value)
    );

    // 1-cycle-latency memory; output holds when no read is issued
    always @(posedge clk) if (clk_en && dm_rd_en) dm_rd_data <= mem[dm_rd_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_addr"}, out_addr, 32'h0);
        chk({tag, "_data"}, out_data, 32'h0);
        chk({tag, "_watch"}, watch_value, 32'h0);
        chk({tag, "_flags"}, 32'({out_valid, dm_rd_en, dm_rd_addr, out_last, busy, done,
                                  watch_hit}), 32'h0);
    endtask

    task automatic push_dump(input logic [1:0] err);
        rec_t r;
        r.a = 32'hFFFF_FFFF;
        r.d = {30'b0, err};
        r.l = 1'b0;
        sb.push_back(r);
        exp_count = 1;
        for (int i = 0; i < 1024; i++) begin
`ifdef DUMP_SKIP_ZERO_EN
            if (mem[i] == 32'h0 && i != 1023) continue;
`endif
            r.a = 32'(i) << 2;
            r.d = mem[i];
            r.l = (i == 1023);
            sb.push_back(r);
            exp_count++;
        end
    endtask

    task automatic pulse_halt();
        halt_f = 1'b1;
        tick();
        halt_f = 1'b0;
    endtask

    task automatic wait_send(input logic [31:0] addr);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (out_valid && out_addr == addr) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("wait_send", 32'(ok), 32'h1);
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("wait_done", 32'(ok), 32'h1);
    endtask

    // Monitor: a record is consumed on a clk_en edge with valid & ready
    always @(negedge clk) begin
        if (rst && clk_en && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_rec: got addr %h data %h, none expected", out_addr,
                         out_data);
            end else begin
                rec_t e;
                e = sb.pop_front();
                chk("rec_addr", out_addr, e.a);
                chk("rec_data", out_data, e.d);
                chk("rec_last", 32'(out_last), 32'(e.l));
            end
            rx_count++;
        end
    end

    initial begin
        rst = 1'b0;
        clk_en = 1'b1;
        halt_f = 1'b0;
        err_bits = 2'b00;
        out_ready = 1'b1;

        // Reset held with random inputs
        for (int i = 0; i < 8; i++) begin
            halt_f = 1'($urandom);
            err_bits = 2'($urandom);
            out_ready = 1'($urandom);
            clk_en = 1'($urandom);
            tick();
            check_zero("rst_hold");
        end
        // Release with halt_f already high: must be ignored
        clk_en = 1'b1;
        out_ready = 1'b1;
        err_bits = 2'b11;
        halt_f = 1'b1;
        rst = 1'b1;
        tick();
        halt_f = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("post_rst_valid", 32'(out_valid), 32'h0);
        chk("post_rst_busy", 32'(busy), 32'h0);

        // Full dump with backpressure, clk_en gaps and stray halts
        for (int i = 0; i < 1024; i++) mem[i] = (i % 7 == 0) ? 32'h0 : 32'(i) * 32'h0101_0101 + 32'h5;
        mem[100] = 32'h32;
        err_bits = 2'b01;
        push_dump(2'b01);
        rx_count = 0;
        pulse_halt();
        err_bits = 2'b10;
        chk("busy_after_halt", 32'(busy), 32'h1);
        chk("hdr_addr", out_addr, 32'hFFFF_FFFF);
        chk("hdr_data", out_data, 32'h1);

        wait_send(32'h0000_000C);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(out_valid), 32'h1);
            chk("bp_addr", out_addr, 32'h0000_000C);
            chk("bp_data", out_data, mem[3]);
        end
        out_ready = 1'b1;
        pulse_halt();

        wait_send(32'h0000_0040);
        clk_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("ce_rd_en", 32'(dm_rd_en), 32'h0);
            chk("ce_valid", 32'(out_valid), 32'h1);
            chk("ce_addr", out_addr, 32'h0000_0040);
            chk("ce_data", out_data, mem[16]);
            chk("ce_ptr", 32'(dm_rd_addr), 32'd16);
        end
        clk_en = 1'b1;

        // Gate clk_en while a read is being strobed
        for (int i = 0; i < 20 && !dm_rd_en; i++) tick();
        chk("rd_seen", 32'(dm_rd_en), 32'h1);
        clk_en = 1'b0;
        #1;
        chk("ce_read_gate", 32'(dm_rd_en), 32'h0);
        tick();
        clk_en = 1'b1;

        wait_done();
        chk("d1_count", rx_count, exp_count);
        chk("d1_sb_empty", sb.size(), 0);
        chk("d1_busy", 32'(busy), 32'h0);
        chk("d1_watch_hit", 32'(watch_hit), 32'h1);
        chk("d1_watch_val", watch_value, 32'h32);
        pulse_halt();
        for (int i = 0; i < 20; i++) tick();
        chk("done_halt_count", rx_count, exp_count);
        chk("done_halt_done", 32'(done), 32'h1);
        chk("done_halt_busy", 32'(busy), 32'h0);
        chk("done_halt_valid", 32'(out_valid), 32'h0);

        // Abort mid-dump with reset, then a fresh dump of a mostly-zero memory
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[100] = 32'h32;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        push_dump(2'b10);
        err_bits = 2'b10;
        pulse_halt();
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 4000; i++) begin
                if (dm_rd_addr == 10'd500) begin
                    ok = 1'b1;
                    break;
                end
                tick();
            end
            chk("reach_500", 32'(ok), 32'h1);
        end
        rst = 1'b0;
        #1;
        check_zero("abort");
        sb.delete();
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        push_dump(2'b10);
        rx_count = 0;
        pulse_halt();
        wait_done();
        chk("d2_count", rx_count, exp_count);
        chk("d2_sb_empty", sb.size(), 0);
        chk("d2_watch_hit", 32'(watch_hit), 32'h1);
        chk("d2_watch_val", watch_value, 32'h32);
        chk("d2_busy", 32'(busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
